// File: rtl/remote_comm.sv
// Full-duplex UART link to the robot: sends a 16-bit command as two back-to-back 8N1 bytes
// (high byte first) and receives single response bytes.
module remote_comm #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BaudMid  = 16'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------- transmit
  typedef enum logic [1:0] {TxIdle, TxHigh, TxLow} tx_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_hold_q, tx_hold_d;
  logic [15:0] tx_baud_q, tx_baud_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        cmd_snt_q, cmd_snt_d;
  logic [9:0]  tx_frame;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_hold_q  <= '0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      cmd_snt_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_hold_q  <= tx_hold_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      cmd_snt_q  <= cmd_snt_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_hold_d  = tx_hold_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    cmd_snt_d  = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        // A strobe coinciding with the completion pulse is dropped.
        if (snd_cmd && !cmd_snt_q) begin
          tx_hold_d  = cmd;
          tx_state_d = TxHigh;
          tx_baud_d  = '0;
          tx_bit_d   = '0;
        end
      end
      TxHigh, TxLow: begin
        if (tx_baud_q == BaudLast) begin
          tx_baud_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (tx_state_q == TxHigh) begin
              tx_state_d = TxLow;
            end else begin
              tx_state_d = TxIdle;
              cmd_snt_d  = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q + 16'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // Frame bit 0 is the start bit, bits 1..8 data LSB first, bit 9 the stop bit.
  assign tx_frame = {1'b1, (tx_state_q == TxHigh) ? tx_hold_q[15:8] : tx_hold_q[7:0], 1'b0};
  assign TX       = (tx_state_q == TxIdle) ? 1'b1 : tx_frame[tx_bit_q];
  assign cmd_snt  = cmd_snt_q;

  // ----------------------------------------------------------------- receive
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] rx_baud_q, rx_baud_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  resp_q, resp_d;
  logic        resp_rdy_q, resp_rdy_d;
  logic        rx_start, rx_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign rx_start = (rx_state_q == RxIdle) && rx_prev_q && !rx_sync_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    rx_set     = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_start) begin
          rx_state_d = RxStart;
          rx_baud_d  = '0;
        end
      end
      RxStart: begin
        // Start bit must still be low at its mid-point, otherwise it was a glitch.
        if (rx_baud_q == BaudMid) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      RxData: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      RxStop: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d  = '0;
          rx_state_d = RxIdle;
          if (rx_sync_q) begin
            resp_d = rx_shift_q;
            rx_set = 1'b1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Setting takes priority over any clear in the same cycle.
  always_comb begin
    resp_rdy_d = resp_rdy_q;
    if (clr_resp_rdy || rx_start) begin
      resp_rdy_d = 1'b0;
    end
    if (rx_set) begin
      resp_rdy_d = 1'b1;
    end
  end

  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at BAUD_DIV=16: TX decoded by a UART monitor, RX driven by a
// robot-side UART task.
module tb_remote_comm;

  localparam int Baud = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = '0;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt;
  logic        tx;
  logic        rx_line = 1'b1;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy = 1'b0;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          snt_cnt = 0;
  int          snt_cycle = 0;
  int          n_rdy = 0;
  int          t0 = 0;
  logic [7:0]  tx_bytes[$];

  remote_comm #(.BAUD_DIV(Baud)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd),
    .snd_cmd      (snd_cmd),
    .cmd_snt      (cmd_snt),
    .TX           (tx),
    .RX           (rx_line),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Completion pulse monitor.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (cmd_snt === 1'b1) begin
        snt_cnt++;
        snt_cycle = cyc;
      end
    end
  end

  // UART receiver model on TX; frames overlapping a reset are discarded.
  initial begin
    logic [7:0] b;
    logic       ok;
    forever begin
      @(posedge clk); #2;
      if (rst_n === 1'b1 && tx === 1'b0) begin
        ok = 1'b1;
        b  = '0;
        repeat (Baud / 2) begin
          @(posedge clk); #2;
          if (rst_n !== 1'b1) ok = 1'b0;
        end
        for (int k = 0; k < 9; k++) begin
          repeat (Baud) begin
            @(posedge clk); #2;
            if (rst_n !== 1'b1) ok = 1'b0;
          end
          if (k < 8) b[k] = tx;
          else if (tx !== 1'b1) ok = 1'b0;
        end
        if (ok) tx_bytes.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tx_byte(input int i);
    if (i < tx_bytes.size()) return tx_bytes[i];
    return 8'hxx;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_cmd(input logic [15:0] c, output int t);
    cmd     = c;
    snd_cmd = 1'b1;
    t       = cyc;
    step(1);
    snd_cmd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_line = 1'b0;
    step(Baud);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      step(Baud);
    end
    rx_line = stop;
    step(Baud);
    rx_line = 1'b1;
  endtask

  initial begin
    // Reset state
    step(3);
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_cmd_snt", 32'(cmd_snt), 32'h0);
    check("reset_resp", 32'(resp), 32'h00);
    check("reset_resp_rdy", 32'(resp_rdy), 32'h0);
    rst_n = 1'b1;
    step(5);

    // Basic command 0x2951
    pulse_cmd(16'h2951, t0);
    goto(t0 + 340);
    check("cmd1_nbytes", 32'(tx_bytes.size()), 32'd2);
    check("cmd1_byte_hi", 32'(tx_byte(0)), 32'h29);
    check("cmd1_byte_lo", 32'(tx_byte(1)), 32'h51);
    check("cmd1_snt_count", 32'(snt_cnt), 32'd1);
    check("cmd1_latency", 32'(snt_cycle - t0), 32'd321);

    // Strobes during the frame and in the completion cycle are ignored
    tx_bytes.delete();
    snt_cnt = 0;
    pulse_cmd(16'h2951, t0);
    goto(t0 + 50);
    cmd = 16'hFFFF; snd_cmd = 1'b1; step(1); snd_cmd = 1'b0;
    goto(t0 + 321);
    check("cmd2_snt_pulse", 32'(cmd_snt), 32'h1);
    cmd = 16'hAAAA; snd_cmd = 1'b1; step(1); snd_cmd = 1'b0;
    goto(t0 + 345);
    check("cmd2_tx_idle_after", 32'(tx), 32'h1);
    goto(t0 + 360);
    check("cmd2_nbytes", 32'(tx_bytes.size()), 32'd2);
    check("cmd2_byte_hi", 32'(tx_byte(0)), 32'h29);
    check("cmd2_byte_lo", 32'(tx_byte(1)), 32'h51);
    check("cmd2_snt_count", 32'(snt_cnt), 32'd1);

    // Receive 0xA5, then clear
    send_rx(8'hA5, 1'b1);
    check("rx_a5_resp", 32'(resp), 32'hA5);
    check("rx_a5_rdy", 32'(resp_rdy), 32'h1);
    clr_resp_rdy = 1'b1; step(1); clr_resp_rdy = 1'b0;
    check("rx_a5_rdy_cleared", 32'(resp_rdy), 32'h0);
    check("rx_a5_resp_kept", 32'(resp), 32'hA5);

    // Clear held through a whole reception: set wins for exactly one cycle
    clr_resp_rdy = 1'b1;
    n_rdy = 0;
    fork
      send_rx(8'h3C, 1'b1);
      begin
        repeat (170) begin
          @(posedge clk); #2;
          if (resp_rdy === 1'b1) n_rdy++;
        end
      end
    join
    @(posedge clk); #1;
    clr_resp_rdy = 1'b0;
    check("set_wins_rdy_cycles", 32'(n_rdy), 32'd1);
    check("set_wins_resp", 32'(resp), 32'h3C);

    // Framing error and a short glitch produce nothing
    send_rx(8'hC3, 1'b0);
    step(5);
    check("frame_err_rdy", 32'(resp_rdy), 32'h0);
    check("frame_err_resp", 32'(resp), 32'h3C);
    rx_line = 1'b0; step(4); rx_line = 1'b1;
    step(200);
    check("glitch_rdy", 32'(resp_rdy), 32'h0);
    check("glitch_resp", 32'(resp), 32'h3C);

    // Full duplex: receive 0x5A while sending 0x3CC3
    tx_bytes.delete();
    snt_cnt = 0;
    fork
      pulse_cmd(16'h3CC3, t0);
      send_rx(8'h5A, 1'b1);
    join
    goto(t0 + 340);
    check("duplex_resp", 32'(resp), 32'h5A);
    check("duplex_rdy", 32'(resp_rdy), 32'h1);
    check("duplex_nbytes", 32'(tx_bytes.size()), 32'd2);
    check("duplex_byte_hi", 32'(tx_byte(0)), 32'h3C);
    check("duplex_byte_lo", 32'(tx_byte(1)), 32'hC3);

    // Reset during the high byte aborts the command
    tx_bytes.delete();
    snt_cnt = 0;
    pulse_cmd(16'h1234, t0);
    goto(t0 + 60);
    rst_n = 1'b0;
    step(1);
    check("abort_tx_in_reset", 32'(tx), 32'h1);
    check("abort_snt_in_reset", 32'(cmd_snt), 32'h0);
    check("abort_resp_reset", 32'(resp), 32'h00);
    check("abort_rdy_reset", 32'(resp_rdy), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(300);
    check("abort_no_snt", 32'(snt_cnt), 32'd0);
    check("abort_no_bytes", 32'(tx_bytes.size()), 32'd0);
    pulse_cmd(16'h0000, t0);
    goto(t0 + 340);
    check("post_reset_nbytes", 32'(tx_bytes.size()), 32'd2);
    check("post_reset_byte_hi", 32'(tx_byte(0)), 32'h00);
    check("post_reset_byte_lo", 32'(tx_byte(1)), 32'h00);
    check("post_reset_snt_count", 32'(snt_cnt), 32'd1);
    check("post_reset_latency", 32'(snt_cycle - t0), 32'd321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 Parameter: BAUD_DIV, default 5208, clocks per UART bit (50 MHz / 9600 baud); legal range 16..65535.
REQ-002 Port: clk  input  1  system clock; the single clock for all logic.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: cmd  input  16  command word to transmit to the robot.
REQ-005 Port: snd_cmd  input  1  one-cycle strobe that starts transmission of cmd.
REQ-006 Port: cmd_snt  output  1  one-cycle pulse; both command bytes fully transmitted.
REQ-007 Port: TX  output  1  UART serial output to the robot BLE RX.
REQ-008 Port: RX  input  1  UART serial input from the robot BLE TX (asynchronous).
REQ-009 Port: resp  output  8  last response byte received (0xA5 done, 0x5A in progress).
REQ-010 Port: resp_rdy  output  1  level; a new resp byte is valid.
REQ-011 Port: clr_resp_rdy  input  1  strobe that clears resp_rdy.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly BAUD_DIV clocks.
REQ-013 Transmit FSM SHALL have states IDLE, HIGH, LOW.
REQ-014 IDLE: snd_cmd=1 captures cmd into a 16-bit holding register and enters HIGH on the same clock edge; TX start bit begins the next cycle.
REQ-015 HIGH SHALL send cmd[15:8]; the LOW start bit SHALL begin on the cycle immediately after the HIGH stop bit ends, with no idle gap.
REQ-016 LOW SHALL send cmd[7:0]; when its stop bit completes, cmd_snt SHALL pulse high for exactly 1 cycle and the FSM SHALL return to IDLE.
REQ-017 snd_cmd asserted in HIGH or LOW SHALL be ignored; the holding register SHALL NOT change and the frame in flight SHALL NOT be disturbed.
REQ-018 snd_cmd in the same cycle as the cmd_snt pulse SHALL be ignored; a new command is accepted from the following cycle.
REQ-019 Total latency from snd_cmd to cmd_snt SHALL be 20*BAUD_DIV+1 clocks.
REQ-020 TX SHALL be 1 whenever the transmit FSM is in IDLE.
REQ-021 RX SHALL pass through a 2-flop synchronizer, both flops resetting to 1; all receive logic SHALL use only the synchronized value.
REQ-022 The receiver SHALL detect a start bit on a 1->0 transition of synchronized RX while idle.
REQ-023 The receiver SHALL re-sample the start bit at BAUD_DIV/2 clocks; if it reads 1, it SHALL return to idle as a glitch.
REQ-024 The receiver SHALL sample each data bit and the stop bit every BAUD_DIV clocks after the start-bit mid-point, shifting data LSB first.
REQ-025 Stop bit sampled 1: resp SHALL load the shifted byte and resp_rdy SHALL set on the next cycle.
REQ-026 Stop bit sampled 0 (framing error): the byte SHALL be discarded, and resp and resp_rdy SHALL be unchanged.
REQ-027 resp_rdy SHALL clear on clr_resp_rdy or on detection of a new start bit.
REQ-028 If a set of resp_rdy and a clear of resp_rdy occur in the same cycle, the set SHALL win.
REQ-029 Transmit and receive paths SHALL operate concurrently (full duplex) with no shared state.
REQ-030 Bit-period and bit-index counters SHALL be sized for BAUD_DIV and SHALL never wrap within a frame.

Reset
REQ-031 When rst_n=0 at a clock edge, the following SHALL take these values on that edge, including mid-frame:
- TX=1, cmd_snt=0, resp=0x00, resp_rdy=0;
- both FSMs to idle;
- all counters to 0.
REQ-032 A frame interrupted by reset SHALL NOT be resumed after reset.

Verification (BAUD_DIV=16, TX looped through a UART model)
REQ-033 cmd=0x2951, snd_cmd pulse: TX shows byte 0x29 then byte 0x51 back-to-back, and cmd_snt pulses exactly 321 clocks after snd_cmd.
REQ-034 Second snd_cmd with cmd=0xFFFF, issued 50 clocks into a frame: transmitted bytes remain 0x29, 0x51; only one cmd_snt pulse occurs.
REQ-035 Robot model sends 0xA5 on RX: resp=0xA5 and resp_rdy=1; then clr_resp_rdy pulse gives resp_rdy=0 with resp still 0xA5.
REQ-036 RX frame with stop bit forced to 0: resp_rdy stays 0 and resp keeps its prior value; a 4-clock low glitch on RX produces no byte.
REQ-037 rst_n low during the HIGH byte, then a new cmd=0x0000 sent: TX=1 during reset, no cmd_snt pulse for the aborted command, and clean frames 0x00, 0x00 follow.
REQ-038 0x5A received while a command is transmitting: resp=0x5A correct and TX byte stream unaffected.
